ahb3lite_timer: RTL and testbench
=================================

// Module: ahb3lite_timer
// PURPOSE
//  Multi-channel down-counting timer; AHB3-Lite slave on the Cortex-M0 interconnect (e.g. base 0x4000_1000).
//  Replaces software busy-wait loops with hardware delays: one-shot or periodic, per-channel prescaler, level IRQ per channel.
// PARAMETERS
//  g_channels        4   number of independent timer channels (1..16)
//  g_timer_width     32  counter/LOAD width in bits (8..g_hdata_size)
//  g_prescale_width  8   prescaler field width; tick every (PRESCALE+1) hclk cycles
//  g_haddr_size      32  AHB address width
//  g_hdata_size      32  AHB data width
// PORTS
//  hclk_i       in   1             bus/timer clock
//  hreset_n_i   in   1             asynchronous active-low reset
//  hsel_i       in   1             slave select
//  haddr_i      in   g_haddr_size  address
//  hwdata_i     in   g_hdata_size  write data (data phase)
//  hrdata_o     out  g_hdata_size  read data (data phase)
//  hwrite_i     in   1             1=write
//  hsize_i      in   3             transfer size; only 3'b010 (word) legal
//  hburst_i     in   3             ignored
//  hprot_i      in   4             ignored
//  htrans_i     in   2             transfer type; active when htrans_i[1]=1
//  hreadyout_o  out  1             slave ready
//  hready_i     in   1             bus ready (qualifies address phase)
//  hresp_o      out  1             0=OKAY 1=ERROR
//  irq_o        out  g_channels    per-channel interrupt, level, = STATUS.expired & CTRL.irq_en
// BEHAVIOUR
//  Reset: all registers 0; hrdata_o=0, hreadyout_o=1, hresp_o=0, irq_o=0; all channels disabled.
//  Map: channel c at offset c*0x10; word index haddr_i[3:2]: 0 CTRL rw, 1 LOAD rw, 2 COUNT ro, 3 STATUS w1c.
//   CTRL: [0] en, [1] periodic (0=one-shot), [2] irq_en, [8+:g_prescale_width] PRESCALE; other bits read 0.
//   STATUS: [0] expired. Reads zero-extend to g_hdata_size. Channel index >= g_channels reads 0, writes ignored.
//  Bus: address phase accepted when hsel_i & hready_i & htrans_i[1]; addr/write/size registered.
//   Word access: zero wait state; write committed at end of data phase from hwdata_i; read data valid in data phase.
//   Non-word hsize: two-cycle ERROR (cycle1 hreadyout_o=0,hresp_o=1; cycle2 hreadyout_o=1,hresp_o=1); no register change.
//   IDLE/BUSY or hsel_i=0: OKAY, zero wait, no side effects. Back-to-back transfers fully supported.
//  Channel FSM: IDLE -> RUN on CTRL write with en 0->1 (COUNT<=LOAD, prescaler cnt<=0).
//   RUN: prescaler counts 0..PRESCALE, tick at PRESCALE; on tick COUNT-=1; if COUNT==0 on tick -> expire.
//   expire: STATUS.expired<=1; periodic: COUNT<=LOAD, stay RUN; one-shot: CTRL.en<=0, -> IDLE, COUNT holds 0.
//   LOAD=0: expires on first tick (and every tick if periodic).
//   en 1->0 write: -> IDLE, COUNT frozen. Writes to LOAD in RUN take effect at next reload only.
//   CTRL write with en staying 1: updates mode/irq_en/PRESCALE, no restart.
//  Simultaneous: expire and W1C of STATUS in same cycle -> expired stays 1 (set wins).
//   One-shot expiry and CTRL write in same cycle -> bus write wins for en.
//  hreset_n_i mid-count: immediate return to reset values, irq_o drops asynchronously.
// STRUCTURE
//  Package ahb3lite_timer_pkg: register word offsets, CTRL bit positions, HTRANS_*/HSIZE_WORD/HRESP_* constants,
//   typedef channel state enum {CH_IDLE, CH_RUN}, typedef bus state enum {BUS_OK, BUS_ERR1}.
//  Top: AHB address-phase register, error FSM, write strobes, read mux.
//  Sub-module ahb3lite_timer_channel (one per channel, generate loop): CTRL/LOAD/COUNT/STATUS, prescaler, FSM, irq.
// TESTING
//  Reset: read all 4 words of ch0..3 -> 0; hreadyout_o=1, irq_o=0.
//  ch0 LOAD=5, CTRL=0x5 (en,irq, one-shot, PRESCALE=0) -> irq_o[0] rises 6 cycles after write; CTRL.en reads 0, COUNT=0.
//  ch1 LOAD=3, CTRL=0x0307 (periodic, PRESCALE=3) -> expire every 16 cycles; W1C STATUS=1 clears irq_o[1] until next expiry.
//  W1C of ch1 STATUS on expiry cycle -> STATUS.expired reads 1.
//  Byte write (hsize=0) to ch0 LOAD -> ERROR, hreadyout_o low 1 cycle, LOAD unchanged; next word read OKAY.
//  Reset asserted mid periodic count on ch2 -> all regs 0, irq_o=0; after release, counting does not resume.

Source files
------------

// File: rtl/ahb3lite_timer_pkg.sv
// Shared register map, AHB encodings and state types for the multi-channel timer.
package ahb3lite_timer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_EN_BIT        = 0;
   localparam int CTRL_PERIODIC_BIT  = 1;
   localparam int CTRL_IRQ_EN_BIT    = 2;
   localparam int CTRL_PRESCALE_LSB  = 8;
   localparam int STATUS_EXPIRED_BIT = 0;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;
   typedef enum logic {BUS_OK, BUS_ERR1} bus_state_e;

endpackage

// File: rtl/ahb3lite_timer_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT/STATUS, prescaler, run FSM, level irq.
// Writes land the cycle after the strobe; read data is combinational; never stalls the bus.
module ahb3lite_timer_channel
   import ahb3lite_timer_pkg::*;
#(
   parameter int g_timer_width    = 32,
   parameter int g_prescale_width = 8,
   parameter int g_hdata_size     = 32
) (
   input  logic                    hclk_i,
   input  logic                    hreset_n_i,
   input  logic                    wr_i,
   input  logic [1:0]              reg_idx_i,
   input  logic [g_hdata_size-1:0] wdata_i,
   output logic [g_hdata_size-1:0] rdata_o,
   output logic                    irq_o
);

   ch_state_e                   state_q, state_d;
   logic                        periodic_q, periodic_d;
   logic                        irq_en_q, irq_en_d;
   logic [g_prescale_width-1:0] prescale_q, prescale_d;
   logic [g_prescale_width-1:0] presc_cnt_q, presc_cnt_d;
   logic [g_timer_width-1:0]    load_q, load_d;
   logic [g_timer_width-1:0]    count_q, count_d;
   logic                        expired_q, expired_d;

   logic wr_ctrl, wr_load, wr_status, wr_en_bit;
   logic running, start, tick, expire;
   logic unused_wdata;

   assign wr_ctrl      = wr_i && (reg_idx_i == REG_CTRL);
   assign wr_load      = wr_i && (reg_idx_i == REG_LOAD);
   assign wr_status    = wr_i && (reg_idx_i == REG_STATUS);
   assign wr_en_bit    = wdata_i[CTRL_EN_BIT];
   assign unused_wdata = ^wdata_i;

   always_ff @(posedge hclk_i or negedge hreset_n_i) begin
      if (!hreset_n_i) begin
         state_q <= CH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A bus CTRL write always decides en, even against a one-shot expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CH_IDLE: if (wr_ctrl && wr_en_bit) state_d = CH_RUN;
         CH_RUN: begin
            if (wr_ctrl)                     state_d = wr_en_bit ? CH_RUN : CH_IDLE;
            else if (expire && !periodic_q)  state_d = CH_IDLE;
         end
      endcase
   end

   always_comb begin
      running = (state_q == CH_RUN);
      start   = (state_q == CH_IDLE) && wr_ctrl && wr_en_bit;
      tick    = running && (presc_cnt_q >= prescale_q);
      expire  = tick && (count_q == '0);
   end

   always_comb begin
      periodic_d  = periodic_q;
      irq_en_d    = irq_en_q;
      prescale_d  = prescale_q;
      load_d      = load_q;
      presc_cnt_d = presc_cnt_q;
      count_d     = count_q;
      expired_d   = expired_q;
      if (wr_ctrl) begin
         periodic_d = wdata_i[CTRL_PERIODIC_BIT];
         irq_en_d   = wdata_i[CTRL_IRQ_EN_BIT];
         prescale_d = wdata_i[CTRL_PRESCALE_LSB +: g_prescale_width];
      end
      if (wr_load) load_d = wdata_i[g_timer_width-1:0];
      if (start) begin
         presc_cnt_d = '0;
         count_d     = load_q;
      end else if (running) begin
         presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
         if (tick) begin
            if (!expire)        count_d = count_q - 1'b1;
            else if (periodic_q) count_d = load_q;
         end
      end
      // Expiry beats a same-cycle W1C so no event is lost.
      if (expire)                                             expired_d = 1'b1;
      else if (wr_status && wdata_i[STATUS_EXPIRED_BIT])      expired_d = 1'b0;
   end

   always_ff @(posedge hclk_i or negedge hreset_n_i) begin
      if (!hreset_n_i) begin
         periodic_q  <= 1'b0;
         irq_en_q    <= 1'b0;
         prescale_q  <= '0;
         presc_cnt_q <= '0;
         load_q      <= '0;
         count_q     <= '0;
         expired_q   <= 1'b0;
      end else begin
         periodic_q  <= periodic_d;
         irq_en_q    <= irq_en_d;
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
         load_q      <= load_d;
         count_q     <= count_d;
         expired_q   <= expired_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (reg_idx_i)
         REG_CTRL: begin
            rdata_o[CTRL_EN_BIT]       = running;
            rdata_o[CTRL_PERIODIC_BIT] = periodic_q;
            rdata_o[CTRL_IRQ_EN_BIT]   = irq_en_q;
            rdata_o[CTRL_PRESCALE_LSB +: g_prescale_width] = prescale_q;
         end
         REG_LOAD:   rdata_o[g_timer_width-1:0] = load_q;
         REG_COUNT:  rdata_o[g_timer_width-1:0] = count_q;
         REG_STATUS: rdata_o[STATUS_EXPIRED_BIT] = expired_q;
      endcase
   end

   assign irq_o = expired_q & irq_en_q;

endmodule

// File: rtl/ahb3lite_timer.sv
// AHB3-Lite slave front end for the timer channels: zero-wait word access, two-cycle ERROR otherwise.
// Reads return in the data phase, writes commit at its end; hreadyout_o drops only in ERROR cycle 1.
module ahb3lite_timer
   import ahb3lite_timer_pkg::*;
#(
   parameter int g_channels       = 4,
   parameter int g_timer_width    = 32,
   parameter int g_prescale_width = 8,
   parameter int g_haddr_size     = 32,
   parameter int g_hdata_size     = 32
) (
   input  logic                    hclk_i,
   input  logic                    hreset_n_i,
   input  logic                    hsel_i,
   input  logic [g_haddr_size-1:0] haddr_i,
   input  logic [g_hdata_size-1:0] hwdata_i,
   output logic [g_hdata_size-1:0] hrdata_o,
   input  logic                    hwrite_i,
   input  logic [2:0]              hsize_i,
   input  logic [2:0]              hburst_i,
   input  logic [3:0]              hprot_i,
   input  logic [1:0]              htrans_i,
   output logic                    hreadyout_o,
   input  logic                    hready_i,
   output logic                    hresp_o,
   output logic [g_channels-1:0]   irq_o
);

   logic       accept;
   logic       dph_vld_q, dph_vld_d;
   logic       dph_write_q, dph_write_d;
   logic [2:0] dph_size_q, dph_size_d;
   logic [7:0] dph_addr_q, dph_addr_d;
   bus_state_e bus_q, bus_d;
   logic       err2_q, err2_d;
   logic       dph_word, wr_stb, rd_act;
   logic [3:0] ch_idx;
   logic [1:0] reg_idx;
   logic [g_channels-1:0]   ch_wr;
   logic [g_hdata_size-1:0] ch_rdata [g_channels];
   logic       unused_bus;

   assign accept     = hsel_i && hready_i && ((htrans_i & HTRANS_NONSEQ) != HTRANS_IDLE);
   assign unused_bus = ^{hburst_i, hprot_i, haddr_i};

   always_comb begin
      dph_vld_d   = accept;
      dph_write_d = dph_write_q;
      dph_size_d  = dph_size_q;
      dph_addr_d  = dph_addr_q;
      if (accept) begin
         dph_write_d = hwrite_i;
         dph_size_d  = hsize_i;
         dph_addr_d  = haddr_i[7:0];
      end
   end

   always_ff @(posedge hclk_i or negedge hreset_n_i) begin
      if (!hreset_n_i) begin
         dph_vld_q   <= 1'b0;
         dph_write_q <= 1'b0;
         dph_size_q  <= HSIZE_WORD;
         dph_addr_q  <= '0;
         bus_q       <= BUS_OK;
         err2_q      <= 1'b0;
      end else begin
         dph_vld_q   <= dph_vld_d;
         dph_write_q <= dph_write_d;
         dph_size_q  <= dph_size_d;
         dph_addr_q  <= dph_addr_d;
         bus_q       <= bus_d;
         err2_q      <= err2_d;
      end
   end

   // Second ERROR cycle is tracked by err2_q so the bus can take a new address phase there.
   always_comb begin
      bus_d  = bus_q;
      err2_d = 1'b0;
      case (bus_q)
         BUS_OK:   if (accept && (hsize_i != HSIZE_WORD)) bus_d = BUS_ERR1;
         BUS_ERR1: begin
            bus_d  = BUS_OK;
            err2_d = 1'b1;
         end
      endcase
   end

   always_comb begin
      hreadyout_o = 1'b1;
      hresp_o     = HRESP_OKAY;
      if (bus_q == BUS_ERR1) begin
         hreadyout_o = 1'b0;
         hresp_o     = HRESP_ERROR;
      end else if (err2_q) begin
         hresp_o     = HRESP_ERROR;
      end
   end

   assign dph_word = (dph_size_q == HSIZE_WORD);
   assign wr_stb   = dph_vld_q && dph_write_q && dph_word;
   assign rd_act   = dph_vld_q && !dph_write_q && dph_word;
   assign ch_idx   = dph_addr_q[7:4];
   assign reg_idx  = dph_addr_q[3:2];

   for (genvar c = 0; c < g_channels; c++) begin : g_ch
      assign ch_wr[c] = wr_stb && (ch_idx == 4'(c));
      ahb3lite_timer_channel #(
         .g_timer_width   (g_timer_width),
         .g_prescale_width(g_prescale_width),
         .g_hdata_size    (g_hdata_size)
      ) u_ch (
         .hclk_i    (hclk_i),
         .hreset_n_i(hreset_n_i),
         .wr_i      (ch_wr[c]),
         .reg_idx_i (reg_idx),
         .wdata_i   (hwdata_i),
         .rdata_o   (ch_rdata[c]),
         .irq_o     (irq_o[c])
      );
   end

   // Unpopulated channel slots match no index and therefore read as zero.
   always_comb begin
      hrdata_o = '0;
      if (rd_act) begin
         for (int c = 0; c < g_channels; c++) begin
            if (ch_idx == 4'(c)) hrdata_o = ch_rdata[c];
         end
      end
   end

endmodule

// File: tb/tb_ahb3lite_timer.sv
// Directed bench for ahb3lite_timer with an arithmetic reference model of each channel.
module tb_ahb3lite_timer;
   import ahb3lite_timer_pkg::*;

   localparam int NCH = 4;

   logic        hclk = 1'b0;
   logic        hreset_n = 1'b0;
   logic        hsel = 1'b0;
   logic        hwrite = 1'b0;
   logic        hready;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic [31:0] hrdata;
   logic [2:0]  hsize = 3'b010;
   logic [2:0]  hburst = '0;
   logic [3:0]  hprot = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hreadyout, hresp;
   logic [NCH-1:0] irq;

   assign hready = hreadyout;
   always #5 hclk = ~hclk;

   ahb3lite_timer dut (
      .hclk_i(hclk), .hreset_n_i(hreset_n), .hsel_i(hsel), .haddr_i(haddr),
      .hwdata_i(hwdata), .hrdata_o(hrdata), .hwrite_i(hwrite), .hsize_i(hsize),
      .hburst_i(hburst), .hprot_i(hprot), .htrans_i(htrans), .hreadyout_o(hreadyout),
      .hready_i(hready), .hresp_o(hresp), .irq_o(irq)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit run_chk = 0;

   // Reference model: a running channel is described only by its start edge,
   // LOAD and PRESCALE; counts and expiries follow by division.
   bit m_en[NCH], m_per[NCH], m_irqen[NCH], m_exp[NCH];
   int m_presc[NCH], m_load[NCH], m_L[NCH], m_P[NCH], m_t0[NCH], m_cnt[NCH];
   bit          pend_vld = 0;
   logic [31:0] pend_addr, pend_dat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_en[c] = 0; m_per[c] = 0; m_irqen[c] = 0; m_exp[c] = 0;
         m_presc[c] = 0; m_load[c] = 0; m_L[c] = 0; m_P[c] = 0; m_t0[c] = 0; m_cnt[c] = 0;
      end
      pend_vld = 0;
   endtask

   function automatic int m_count(int c);
      int n;
      if (!m_en[c]) return m_cnt[c];
      n = (cyc - m_t0[c]) / (m_P[c] + 1);
      if (m_per[c]) return m_L[c] - (n % (m_L[c] + 1));
      return m_L[c] - n;
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] a);
      int ch;
      ch = int'(a[7:4]);
      if (ch >= NCH) return 32'h0;
      case (a[3:2])
         2'd0: return {16'h0, 8'(m_presc[ch]), 5'h0, m_irqen[ch], m_per[ch], m_en[ch]};
         2'd1: return 32'(m_load[ch]);
         2'd2: return 32'(m_count(ch));
         default: return {31'h0, m_exp[ch]};
      endcase
   endfunction

   task automatic m_step();
      bit now[NCH];
      int ch;
      for (int c = 0; c < NCH; c++) begin
         int d;
         now[c] = 0;
         d = cyc - m_t0[c];
         if (m_en[c] && d > 0 && d % (m_P[c] + 1) == 0 && (d / (m_P[c] + 1)) % (m_L[c] + 1) == 0) begin
            now[c] = 1;
            m_exp[c] = 1;
            if (!m_per[c]) begin
               m_en[c] = 0;
               m_cnt[c] = 0;
            end
         end
      end
      if (pend_vld) begin
         pend_vld = 0;
         ch = int'(pend_addr[7:4]);
         if (ch < NCH) begin
            case (pend_addr[3:2])
               2'd0: begin
                  m_per[ch] = pend_dat[1];
                  m_irqen[ch] = pend_dat[2];
                  m_presc[ch] = int'(pend_dat[15:8]);
                  if (pend_dat[0] && !m_en[ch]) begin
                     m_en[ch] = 1; m_t0[ch] = cyc; m_L[ch] = m_load[ch]; m_P[ch] = m_presc[ch];
                  end else if (!pend_dat[0] && m_en[ch]) begin
                     m_cnt[ch] = m_count(ch);
                     m_en[ch] = 0;
                  end
               end
               2'd1: m_load[ch] = int'(pend_dat);
               2'd3: if (pend_dat[0] && !now[ch]) m_exp[ch] = 0;
               default: ;
            endcase
         end
      end
   endtask

   always @(posedge hclk) begin
      cyc++;
      if (!hreset_n) m_reset();
      else m_step();
   end

   always @(negedge hclk) begin
      if (run_chk) begin
         logic [NCH-1:0] e;
         for (int c = 0; c < NCH; c++) e[c] = m_exp[c] & m_irqen[c];
         check("irq_cycle", 32'(irq), 32'(e));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      hsel = 1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = 1; hsize = HSIZE_WORD;
      step(1);
      hsel = 0; htrans = HTRANS_IDLE; hwrite = 0; hwdata = d;
      pend_addr = a; pend_dat = d; pend_vld = 1;
      step(1);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, input string name);
      hsel = 1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = 0; hsize = HSIZE_WORD;
      step(1);
      hsel = 0; htrans = HTRANS_IDLE;
      @(negedge hclk);
      d = hrdata;
      check(name, hrdata, m_read(a));
      check({name, "_resp"}, 32'(hresp), 32'(HRESP_OKAY));
      step(1);
   endtask

   task automatic err_wr(input logic [31:0] a, input logic [31:0] d);
      hsel = 1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = 1; hsize = 3'b000;
      step(1);
      hsel = 0; htrans = HTRANS_IDLE; hwrite = 0; hsize = HSIZE_WORD; hwdata = d;
      @(negedge hclk);
      check("err_c1_ready", 32'(hreadyout), 32'd0);
      check("err_c1_resp", 32'(hresp), 32'd1);
      step(1);
      @(negedge hclk);
      check("err_c2_ready", 32'(hreadyout), 32'd1);
      check("err_c2_resp", 32'(hresp), 32'd1);
      step(1);
   endtask

   task automatic wait_irq(input int c, input int budget, input string name, output int at);
      bit found = 0;
      at = 0;
      for (int i = 0; i < budget && !found; i++) begin
         step(1);
         if (irq[c]) begin
            found = 1;
            at = cyc;
         end
      end
      check(name, 32'(found), 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      int t_commit, a1, a2, a3;
      m_reset();
      step(3);
      hreset_n = 1;
      run_chk = 1;
      check("rst_hreadyout", 32'(hreadyout), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      for (int c = 0; c < NCH; c++)
         for (int w = 0; w < 4; w++) begin
            rd(32'(c * 16 + w * 4), d, "rst_rd");
            check("rst_rd_zero", d, 32'h0);
         end

      // ch0 one-shot, LOAD=5, PRESCALE=0
      wr(32'h04, 32'd5);
      t_commit = cyc + 2;
      wr(32'h00, 32'h5);
      wait_irq(0, 30, "ch0_irq_seen", a1);
      check("ch0_irq_delay", 32'(a1 - t_commit), 32'd6);
      rd(32'h00, d, "ch0_ctrl");
      check("ch0_ctrl_lit", d, 32'h4);
      rd(32'h08, d, "ch0_count");
      check("ch0_count_lit", d, 32'h0);
      rd(32'h0C, d, "ch0_status");
      check("ch0_status_lit", d, 32'h1);
      wr(32'h0C, 32'h1);

      // ch1 periodic, LOAD=3, PRESCALE=3
      wr(32'h14, 32'd3);
      t_commit = cyc + 2;
      wr(32'h10, 32'h0307);
      wait_irq(1, 40, "ch1_irq_seen1", a1);
      check("ch1_first_period", 32'(a1 - t_commit), 32'd16);
      wr(32'h1C, 32'h1);
      check("ch1_w1c_clears", 32'(irq[1]), 32'd0);
      wait_irq(1, 40, "ch1_irq_seen2", a2);
      check("ch1_period", 32'(a2 - a1), 32'd16);
      step(14);
      wr(32'h1C, 32'h1);
      rd(32'h1C, d, "ch1_status_setwins");
      check("ch1_status_setwins_lit", d, 32'h1);

      // ch3 stopped mid-count freezes COUNT
      wr(32'h34, 32'd100);
      wr(32'h30, 32'h1);
      step(10);
      wr(32'h30, 32'h0);
      rd(32'h38, d, "ch3_frozen_a");
      check("ch3_frozen_lit", d, 32'd88);
      step(5);
      rd(32'h38, d, "ch3_frozen_b");
      check("ch3_frozen_b_lit", d, 32'd88);

      // unpopulated channel slot
      wr(32'h50, 32'h1);
      rd(32'h50, d, "oor_ctrl");
      check("oor_ctrl_lit", d, 32'h0);

      // byte write to ch0 LOAD
      err_wr(32'h04, 32'hDEAD);
      rd(32'h04, d, "ch0_load_after_err");
      check("ch0_load_after_err_lit", d, 32'd5);

      // reset in the middle of a periodic count on ch2
      wr(32'h24, 32'd2);
      wr(32'h20, 32'h7);
      wait_irq(2, 20, "ch2_irq_seen", a3);
      #3;
      hreset_n = 0;
      m_reset();
      #1;
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_hreadyout", 32'(hreadyout), 32'd1);
      step(2);
      hreset_n = 1;
      step(20);
      for (int w = 0; w < 4; w++) begin
         rd(32'(32'h20 + w * 4), d, "ch2_after_rst");
         check("ch2_after_rst_lit", d, 32'h0);
      end
      check("after_rst_irq", 32'(irq), 32'd0);

      run_chk = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
